// File: rtl/pipe_pkg.sv
// Shared definitions for the IF->ID pipeline register: default widths, NOP encoding, occupancy states.
package pipe_pkg;

  localparam int IFID_AW = 32;
  localparam int IFID_DW = 32;

  // MIPS sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ifid_state_t;

endpackage

// File: rtl/if_id_slot.sv
// One PC+instruction storage slot: loads on enable, clears to PC 0 / RST_INSTR on async reset.
module if_id_slot #(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter logic [DW-1:0]  RST_INSTR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] pc_d,
  input  logic [DW-1:0] instr_d,
  output logic [AW-1:0] pc_q,
  output logic [DW-1:0] instr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= RST_INSTR;
    end else if (load) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer and flush.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int            AW  = IFID_AW,
  parameter int            DW  = IFID_DW,
  parameter logic [DW-1:0] NOP = DW'(NOP_INSTR)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [AW-1:0] InPC,
  input  logic [DW-1:0] InInstr,
  input  logic          InValid,
  output logic          InReady,
  input  logic          Flush,
  output logic [AW-1:0] OutPC,
  output logic [DW-1:0] OutInstr,
  output logic          OutValid,
  input  logic          OutReady,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]   StallCnt,
  output logic [31:0]   FlushCnt,
`endif
  output ifid_state_t   DbgState
);

  // Handshake: a word moves on a side only in a cycle where valid and ready are
  // both high at the rising edge; InReady is a register, never a function of OutReady.

  ifid_state_t   state;
  logic          in_ready_q;
  logic          out_valid;
  logic          accept;
  logic          consume;
  logic          main_load;
  logic          skid_load;
  logic [AW-1:0] main_pc;
  logic [DW-1:0] main_instr;
  logic [AW-1:0] skid_pc;
  logic [DW-1:0] skid_instr;
  logic [AW-1:0] main_pc_d;
  logic [DW-1:0] main_instr_d;

  assign out_valid = (state != EMPTY);
  assign accept    = InValid & in_ready_q & ~Flush;
  assign consume   = out_valid & OutReady;

  // Main refills from the skid only when draining FULL; otherwise straight from IF.
  assign main_load = ~Flush & (((state == EMPTY) & accept) |
                               ((state == ONE) & accept & consume) |
                               ((state == FULL) & consume));
  assign skid_load = (state == ONE) & accept & ~consume;

  assign main_pc_d    = (state == FULL) ? skid_pc    : InPC;
  assign main_instr_d = (state == FULL) ? skid_instr : InInstr;

  if_id_slot #(.AW(AW), .DW(DW), .RST_INSTR(NOP)) u_main (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (main_load),
    .pc_d    (main_pc_d),
    .instr_d (main_instr_d),
    .pc_q    (main_pc),
    .instr_q (main_instr)
  );

  if_id_slot #(.AW(AW), .DW(DW), .RST_INSTR(NOP)) u_skid (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (skid_load),
    .pc_d    (InPC),
    .instr_d (InInstr),
    .pc_q    (skid_pc),
    .instr_q (skid_instr)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else if (Flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state <= ONE;
          in_ready_q <= 1'b1;
        end
        ONE: begin
          if (accept && !consume) begin
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (!accept && consume) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (consume) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid;
  assign OutPC    = main_pc;
  assign OutInstr = out_valid ? main_instr : NOP;
  assign DbgState = state;

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (InValid && !in_ready_q)       StallCnt <= StallCnt + 32'd1;
      if (Flush && (out_valid || InValid)) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed scenarios plus a randomized IF/ID stream against a queue model.
module tb_if_id_pipe_reg;
  import pipe_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] InPC = '0;
  logic [31:0] InInstr = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        Flush = 1'b0;
  logic [31:0] OutPC;
  logic [31:0] OutInstr;
  logic        OutValid;
  logic        OutReady = 1'b0;
  ifid_state_t DbgState;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
`endif

  if_id_pipe_reg dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .InPC     (InPC),
    .InInstr  (InInstr),
    .InValid  (InValid),
    .InReady  (InReady),
    .Flush    (Flush),
    .OutPC    (OutPC),
    .OutInstr (OutInstr),
    .OutValid (OutValid),
    .OutReady (OutReady),
`ifdef IFID_PERF_CNT_EN
    .StallCnt (StallCnt),
    .FlushCnt (FlushCnt),
`endif
    .DbgState (DbgState)
  );

  // clock
  always #5 Clk = ~Clk;

  // reference model: FIFO of {pc,instr} words, capacity 2
  logic [63:0] exp_q[$];
  logic [31:0] shown_pc;
  logic        ready_m;
  int unsigned stall_m;
  int unsigned flush_m;
  int          tests = 0;
  int          fails = 0;
  logic        last_accept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    shown_pc = '0;
    ready_m  = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] front;
    ifid_state_t st_exp;
    front  = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
    st_exp = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? ONE : FULL;
    check({tag, ".valid"}, {63'd0, OutValid}, {63'd0, exp_q.size() > 0});
    check({tag, ".instr"}, {32'd0, OutInstr}, (exp_q.size() > 0) ? {32'd0, front[31:0]} : 64'd0);
    check({tag, ".pc"},    {32'd0, OutPC},    {32'd0, shown_pc});
    check({tag, ".ready"}, {63'd0, InReady},  {63'd0, ready_m});
    check({tag, ".state"}, {62'd0, DbgState}, {62'd0, st_exp});
  endtask

  // driver: present one cycle of inputs, clock it, advance the model, check
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic ordy, input string tag);
    logic acc, con;
    InValid  = v;
    InPC     = pc;
    InInstr  = instr;
    Flush    = fl;
    OutReady = ordy;
    @(posedge Clk);
    acc = v && ready_m && !fl;
    con = (exp_q.size() > 0) && ordy;
    if (v && !ready_m) stall_m++;
    if (fl && ((exp_q.size() > 0) || v)) flush_m++;
    if (fl) exp_q.delete();
    else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc, instr});
    end
    if (exp_q.size() > 0) shown_pc = exp_q[0][63:32];
    ready_m     = (exp_q.size() < 2);
    last_accept = acc;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] src_pc;
    logic [31:0] src_instr;
    model_reset();
    stall_m = 0;
    flush_m = 0;
    last_accept = 1'b0;

    // reset
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset_hold");
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check_outputs("reset_release");

    // streaming
    step(1, 32'd4,  32'hA000_0004, 0, 1, "stream4");
    step(1, 32'd8,  32'hA000_0008, 0, 1, "stream8");
    step(1, 32'd12, 32'hA000_000C, 0, 1, "stream12");
    step(0, 32'd0,  32'h0,         0, 1, "stream_drain");

    // backpressure
    step(1, 32'd4,  32'hB000_0004, 0, 0, "bp4");
    step(1, 32'd8,  32'hB000_0008, 0, 0, "bp8_full");
    step(1, 32'd12, 32'hB000_000C, 0, 0, "bp12_stall1");
    step(1, 32'd12, 32'hB000_000C, 0, 0, "bp12_stall2");
    step(1, 32'd12, 32'hB000_000C, 0, 1, "bp_drain4");
    step(1, 32'd12, 32'hB000_000C, 0, 1, "bp_drain8_acc12");
    step(0, 32'd0,  32'h0,         0, 1, "bp_drain12");

    // flush while FULL with a valid incoming word
    step(1, 32'd4,  32'hC000_0004, 0, 0, "fl_fill4");
    step(1, 32'd8,  32'hC000_0008, 0, 0, "fl_fill8");
    step(1, 32'd16, 32'hC000_0010, 1, 0, "fl_full");
    step(0, 32'd0,  32'h0,         0, 1, "fl_after");
    step(0, 32'd0,  32'h0,         0, 1, "fl_after2");

    // flush coincident with consume
    step(1, 32'd4,  32'hD000_0004, 0, 0, "flc_load4");
    step(0, 32'd0,  32'h0,         1, 1, "flc_consume");
    step(0, 32'd0,  32'h0,         0, 1, "flc_empty");

    // reset mid-stream: outputs clear at the reset edge itself
    step(1, 32'd40, 32'hE000_0028, 0, 0, "rst_load1");
    step(1, 32'd44, 32'hE000_002C, 0, 0, "rst_load2");
    #2;
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    check_outputs("rst_after");
    stall_m = 0;
    flush_m = 0;

    // randomized stream; IF holds its word until accepted
    src_pc    = 32'h0000_1000;
    src_instr = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic v, fl, rd;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 2) != 0);
      step(v, src_pc, src_instr, fl, rd, "rand");
      if (last_accept || fl) begin
        src_pc    = src_pc + 32'd4;
        src_instr = $urandom;
      end
    end

`ifdef IFID_PERF_CNT_EN
    // perf counters: 3 stalled cycles then one flush
    step(0, 32'd0, 32'h0, 1, 1, "pc_clear");
    step(0, 32'd0, 32'h0, 0, 1, "pc_idle");
    stall_m = 0;
    flush_m = 0;
    Rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    step(1, 32'd4,  32'hF000_0004, 0, 0, "pc_fill4");
    step(1, 32'd8,  32'hF000_0008, 0, 0, "pc_fill8");
    step(1, 32'd12, 32'hF000_000C, 0, 0, "pc_stall1");
    step(1, 32'd12, 32'hF000_000C, 0, 0, "pc_stall2");
    step(1, 32'd12, 32'hF000_000C, 0, 0, "pc_stall3");
    step(0, 32'd0,  32'h0,         1, 0, "pc_flush");
    check("stall_cnt", {32'd0, StallCnt}, {32'd0, 32'(stall_m)});
    check("flush_cnt", {32'd0, FlushCnt}, {32'd0, 32'(flush_m)});
    check("stall_cnt_3", {32'd0, StallCnt}, 64'd3);
    check("flush_cnt_1", {32'd0, FlushCnt}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
